// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: synchronises the rows, walks a one-hot
// column drive, debounces press and release, and encodes the key as {row, col}.
`timescale 1ns/1ps

module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Rows,
    output logic [3:0] Cols,
    output logic [3:0] KB,
    output logic       KP
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tcnt_q;
    logic            tick;
    logic [3:0]      rows_meta, rs;
    logic [1:0]      col_q, col_d;
    logic [1:0]      r_q, r_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [3:0]      kb_q, kb_d;
    logic [1:0]      row_hit;
    logic            key_up;

    // Rows are asynchronous to clk; two flops before anything looks at them.
    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rows_meta <= 4'hF;
            rs        <= 4'hF;
        end else begin
            rows_meta <= Rows;
            rs        <= rows_meta;
        end
    end

    // Free-running scan divider; every FSM decision waits for tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
        end else if (tcnt_q == TICK_LAST) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end

    assign tick = (tcnt_q == TICK_LAST);

    // Lowest-numbered low row wins when several rows are pulled down at once.
    always_comb begin
        row_hit = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) row_hit = 2'(i);
        end
    end

    assign key_up = rs[r_q];

    // State register, together with the datapath it steers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SCAN;
            col_q   <= 2'd0;
            r_q     <= 2'd0;
            dcnt_q  <= '0;
            kb_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            r_q     <= r_d;
            dcnt_q  <= dcnt_d;
            kb_q    <= kb_d;
        end
    end

    // Next-state and next-datapath logic.
    // NOTE: every signal written here gets a hold default first, so no path
    // leaves it unassigned and no latch can be inferred.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        r_d     = r_q;
        dcnt_d  = dcnt_q;
        kb_d    = kb_q;
        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (rs != 4'hF) begin
                        r_d     = row_hit;
                        dcnt_d  = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!key_up) begin
                        dcnt_d = dcnt_q + DW'(1);
                        if (dcnt_q == DCNT_LAST) begin
                            kb_d    = {r_q, col_q};
                            state_d = ST_PRESSED;
                        end
                    end else begin
                        col_d   = col_q + 2'd1;
                        state_d = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    if (key_up) begin
                        dcnt_d  = '0;
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (key_up) begin
                        dcnt_d = dcnt_q + DW'(1);
                        if (dcnt_q == DCNT_LAST) begin
                            col_d   = col_q + 2'd1;
                            state_d = ST_SCAN;
                        end
                    end else begin
                        // A bounce during release re-arms the press; KP never drops.
                        dcnt_d  = '0;
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    // Outputs decode registered state only, so there is no path from Rows.
    always_comb begin
        Cols = ~(4'b0001 << col_q);
        KP   = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);
        KB   = kb_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=3) with a keypad model
// where a row is low if any pressed key on it sits in the driven column.
`timescale 1ns/1ps

module tb_keypad_scanner;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  Rows;
    logic [3:0]  Cols;
    logic [3:0]  KB;
    logic        KP;
    logic [15:0] keys  = '0;   // keys[4*row+col] = 1 while that key is held

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            Rows[r] = ~|(keys[r*4 +: 4] & ~Cols);
        end
    end

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Rows (Rows),
        .Cols (Cols),
        .KB   (KB),
        .KP   (KP)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input int r, input int c);
        keys[r*4 + c] = 1'b1;
    endtask

    initial begin
        // 1. reset, then free scanning with no keys; edge numbers count from reset release
        step(2);
        chk("reset_kp",   {3'b0, KP}, 4'h0);
        chk("reset_kb",   KB,         4'h0);
        chk("reset_cols", Cols,       4'b1110);
        reset = 1'b0;
        step(3);
        chk("scan_hold_col0", Cols, 4'b1110);
        step(1);
        chk("scan_col1", Cols, 4'b1101);
        step(4);
        chk("scan_col2", Cols, 4'b1011);
        step(4);
        chk("scan_col3", Cols, 4'b0111);
        step(4);
        chk("scan_wrap", Cols, 4'b1110);
        chk("scan_kp",   {3'b0, KP}, 4'h0);

        // 2. row2/col1: detect tick at edge 24, KP rises at edge 36
        press(2, 1);
        step(19);
        chk("press_pre_kp",   {3'b0, KP}, 4'h0);
        chk("press_freeze",   Cols,       4'b1101);
        step(1);
        chk("press_kp",       {3'b0, KP}, 4'h1);
        chk("press_kb",       KB,         4'h9);
        keys = '0;
        step(15);
        chk("release_pre_kp",   {3'b0, KP}, 4'h1);
        chk("release_pre_cols", Cols,       4'b1101);
        step(1);
        chk("release_kp",   {3'b0, KP}, 4'h0);
        chk("release_cols", Cols,       4'b1011);
        chk("release_kb",   KB,         4'h9);

        // 3. bounce: row2/col1 seen on one tick only (edge 68)
        press(2, 1);
        step(16);
        chk("bounce_detect_cols", Cols,       4'b1101);
        chk("bounce_detect_kp",   {3'b0, KP}, 4'h0);
        keys = '0;
        step(4);
        chk("bounce_resume_cols", Cols,       4'b1011);
        chk("bounce_kp",          {3'b0, KP}, 4'h0);
        chk("bounce_kb",          KB,         4'h9);

        // 4. row1/col3 and row3/col3 together: row1 wins, KP at edge 92
        press(1, 3);
        press(3, 3);
        step(19);
        chk("multi_pre_kp", {3'b0, KP}, 4'h0);
        chk("multi_cols",   Cols,       4'b0111);
        step(1);
        chk("multi_kp", {3'b0, KP}, 4'h1);
        chk("multi_kb", KB,         4'h7);

        // 5. release, bounce back for one tick during RELEASE, release for good
        keys = '0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("rel_bounce_kp_a", {3'b0, KP}, 4'h1);
        end
        press(1, 3);
        press(3, 3);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("rel_bounce_kp_b", {3'b0, KP}, 4'h1);
        end
        keys = '0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            chk("rel_bounce_kp_c", {3'b0, KP}, 4'h1);
        end
        step(1);
        chk("rel_bounce_drop_kp", {3'b0, KP}, 4'h0);
        chk("rel_bounce_cols",    Cols,       4'b1110);
        chk("rel_bounce_kb",      KB,         4'h7);

        // 6. reset while the key is held and KP=1, then re-detection
        press(2, 1);
        step(19);
        chk("rst_pre_kp", {3'b0, KP}, 4'h0);
        step(1);
        chk("rst_press_kp", {3'b0, KP}, 4'h1);
        chk("rst_press_kb", KB,         4'h9);
        reset = 1'b1;
        step(1);
        chk("rst_mid_kp",   {3'b0, KP}, 4'h0);
        chk("rst_mid_cols", Cols,       4'b1110);
        reset = 1'b0;
        step(19);
        chk("rst_redetect_pre_kp", {3'b0, KP}, 4'h0);
        chk("rst_redetect_cols",   Cols,       4'b1101);
        step(1);
        chk("rst_redetect_kp", {3'b0, KP}, 4'h1);
        chk("rst_redetect_kb", KB,         4'h9);
        keys = '0;
        step(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
